// File: rtl/fpu_pkg.sv
// Shared FPU constants: compare op codes, magnitude-compare encodings, IEEE-754 single field widths.
package fpu_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int OP_W  = 3;
  localparam int MAG_W = 2;

  localparam logic [OP_W-1:0] FCMP_FEQ  = 3'b000;
  localparam logic [OP_W-1:0] FCMP_FLT  = 3'b001;
  localparam logic [OP_W-1:0] FCMP_FLE  = 3'b010;
  localparam logic [OP_W-1:0] FCMP_FMIN = 3'b011;
  localparam logic [OP_W-1:0] FCMP_FMAX = 3'b100;

  localparam logic [MAG_W-1:0] MAG_EQ = 2'b00;
  localparam logic [MAG_W-1:0] MAG_GT = 2'b01;
  localparam logic [MAG_W-1:0] MAG_LT = 2'b10;

  localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
    logic sign;
  } fp_class_t;

endpackage

// File: rtl/fcmp_minmax_stage_if.sv
// Issue-side and writeback-side handshake bundle for the compare/min/max stage.
interface fcmp_minmax_stage_if
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  a_op;
  logic [FP_W-1:0]  b_op;
  logic [MAG_W-1:0] mag_res;
  logic [OP_W-1:0]  op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [FP_W-1:0]  result;
  logic             nv;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a_op, b_op, mag_res, op, in_tag, out_ready,
    input  in_ready, out_valid, result, nv, out_tag
  );

  modport slave (
    input  in_valid, a_op, b_op, mag_res, op, in_tag, out_ready,
    output in_ready, out_valid, result, nv, out_tag
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier: NaN, signalling NaN, zero and sign.
module fp_classify
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] i_x,
  output fp_class_t       o_cls
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp = i_x[MAN_W +: EXP_W];
  assign w_man = i_x[MAN_W-1:0];

  always_comb begin
    o_cls.nan  = (w_exp == '1) && (w_man != '0);
    // Quiet bit is the MSB of the mantissa; a NaN without it signals.
    o_cls.snan = o_cls.nan && !w_man[MAN_W-1];
    o_cls.zero = (w_exp == '0) && (w_man == '0);
    o_cls.sign = i_x[FP_W-1];
  end

endmodule

// File: rtl/fcmp_minmax_stage.sv
// Resolves an upstream magnitude compare into FEQ/FLT/FLE/FMIN/FMAX results with NV, in a 2-stage valid/ready pipe.
module fcmp_minmax_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
)(
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                flush,
  fcmp_minmax_stage_if.slave  bus
);

  fp_class_t        w_cls_a;
  fp_class_t        w_cls_b;
  logic             w_stall;
  logic             w_in_ready;

  logic             r_vld_p1;
  logic [FP_W-1:0]  r_a_p1;
  logic [FP_W-1:0]  r_b_p1;
  logic [OP_W-1:0]  r_op_p1;
  logic [MAG_W-1:0] r_mag_p1;
  logic [TAG_W-1:0] r_tag_p1;
  fp_class_t        r_cls_a_p1;
  fp_class_t        r_cls_b_p1;

  logic             r_vld_p2;
  logic [FP_W-1:0]  r_res_p2;
  logic             r_nv_p2;
  logic [TAG_W-1:0] r_tag_p2;

  logic [MAG_W-1:0] w_mag;
  logic             w_any_nan;
  logic             w_any_snan;
  logic             w_both_zero;
  logic             w_lt;
  logic             w_eq;
  logic [FP_W-1:0]  w_min;
  logic [FP_W-1:0]  w_max;
  logic [FP_W-1:0]  w_res;
  logic             w_nv;

  fp_classify u_cls_a (.i_x(bus.a_op), .o_cls(w_cls_a));
  fp_classify u_cls_b (.i_x(bus.b_op), .o_cls(w_cls_b));

  assign w_stall    = r_vld_p2 && !bus.out_ready;
  // Stage 1 may still fill while the output is stalled, as long as it is empty.
  assign w_in_ready = (!w_stall || !r_vld_p1) && !flush;

  // ---- stage 0 -> 1: capture operands and classification
  always_ff @(posedge CLK) begin
    if (w_in_ready && bus.in_valid) begin
      r_a_p1     <= bus.a_op;
      r_b_p1     <= bus.b_op;
      r_op_p1    <= bus.op;
      r_mag_p1   <= bus.mag_res;
      r_tag_p1   <= bus.in_tag;
      r_cls_a_p1 <= w_cls_a;
      r_cls_b_p1 <= w_cls_b;
    end
  end

  // ---- stage 1 -> 2: signed ordering and result selection
  always_comb begin
    w_mag       = (r_mag_p1 == 2'b11) ? MAG_EQ : r_mag_p1;
    w_any_nan   = r_cls_a_p1.nan  || r_cls_b_p1.nan;
    w_any_snan  = r_cls_a_p1.snan || r_cls_b_p1.snan;
    w_both_zero = r_cls_a_p1.zero && r_cls_b_p1.zero;
    w_lt        = 1'b0;
    w_eq        = 1'b0;
    if (w_both_zero) begin
      w_eq = 1'b1;
    end else if (r_cls_a_p1.sign != r_cls_b_p1.sign) begin
      w_lt = r_cls_a_p1.sign;
    end else if (!r_cls_a_p1.sign) begin
      w_lt = (w_mag == MAG_LT);
      w_eq = (w_mag == MAG_EQ);
    end else begin
      // Both negative: larger magnitude is the smaller value.
      w_lt = (w_mag == MAG_GT);
      w_eq = (w_mag == MAG_EQ);
    end

    if (r_cls_a_p1.nan && r_cls_b_p1.nan) begin
      w_min = CANON_NAN;
      w_max = CANON_NAN;
    end else if (r_cls_a_p1.nan) begin
      w_min = r_b_p1;
      w_max = r_b_p1;
    end else if (r_cls_b_p1.nan) begin
      w_min = r_a_p1;
      w_max = r_a_p1;
    end else if (w_both_zero) begin
      // OR of two zeros keeps any minus sign, AND drops it.
      w_min = r_a_p1 | r_b_p1;
      w_max = r_a_p1 & r_b_p1;
    end else begin
      w_min = w_lt ? r_a_p1 : r_b_p1;
      w_max = w_lt ? r_b_p1 : r_a_p1;
    end

    w_res = '0;
    w_nv  = 1'b0;
    case (r_op_p1)
      FCMP_FEQ: begin
        w_res[0] = w_eq && !w_any_nan;
        w_nv     = w_any_snan;
      end
      FCMP_FLT: begin
        w_res[0] = w_lt && !w_any_nan;
        w_nv     = w_any_nan;
      end
      FCMP_FLE: begin
        w_res[0] = (w_lt || w_eq) && !w_any_nan;
        w_nv     = w_any_nan;
      end
      FCMP_FMIN: begin
        w_res = w_min;
        w_nv  = w_any_snan;
      end
      FCMP_FMAX: begin
        w_res = w_max;
        w_nv  = w_any_snan;
      end
      default: begin
        w_res = '0;
        w_nv  = 1'b0;
      end
    endcase
  end

  // ---- stage 2: pipeline control and output registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_res_p2 <= '0;
      r_nv_p2  <= 1'b0;
      r_tag_p2 <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_res_p2 <= w_res;
          r_nv_p2  <= w_nv;
          r_tag_p2 <= r_tag_p1;
        end
      end
      if (w_in_ready) begin
        r_vld_p1 <= bus.in_valid;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.result    = r_res_p2;
  assign bus.nv        = r_nv_p2;
  assign bus.out_tag   = r_tag_p2;

endmodule

// File: tb/tb_fcmp_minmax_stage.sv
// Directed bench for fcmp_minmax_stage: compare/min/max rules, stall hold, flush and mid-stall reset.
module tb_fcmp_minmax_stage;
  import fpu_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fcmp_minmax_stage_if #(.TAG_W(5)) bus ();

  fcmp_minmax_stage #(.TAG_W(5)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .flush(flush), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] mag, input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a_op     = a;
    bus.b_op     = b;
    bus.mag_res  = mag;
    bus.in_tag   = tag;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] mag, input logic [4:0] tag,
                        input logic [31:0] er, input logic en);
    @(negedge CLK);
    drive(op, a, b, mag, tag);
    #1 chk({nm, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    #1 chk({nm, ".lat1"}, {31'b0, bus.out_valid}, 32'd0);
    @(negedge CLK);
    #1;
    chk({nm, ".vld"}, {31'b0, bus.out_valid}, 32'd1);
    chk({nm, ".res"}, bus.result, er);
    chk({nm, ".nv"},  {31'b0, bus.nv}, {31'b0, en});
    chk({nm, ".tag"}, {27'b0, bus.out_tag}, {27'b0, tag});
  endtask

  logic [2:0]  s_op  [4];
  logic [31:0] s_a   [4];
  logic [31:0] s_b   [4];
  logic [1:0]  s_mag [4];
  logic [31:0] s_exp [4];

  initial begin
    int          ix;
    int          rx;
    logic        held;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 3'b0;
    bus.a_op      = 32'h0;
    bus.b_op      = 32'h0;
    bus.mag_res   = 2'b0;
    bus.in_tag    = 5'h0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.result",    bus.result, 32'h0);
    chk("rst.nv",        {31'b0, bus.nv}, 32'd0);
    chk("rst.out_tag",   {27'b0, bus.out_tag}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    #1 chk("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Directed single operations
    run_op("t1.flt_neg_pos", FCMP_FLT,  32'hBF80_0000, 32'h3F80_0000, 2'b00, 5'd1, 32'd1, 1'b0);
    run_op("t2.feq_zeros",   FCMP_FEQ,  32'h0000_0000, 32'h8000_0000, 2'b01, 5'd2, 32'd1, 1'b0);
    run_op("t2.fmin_zeros",  FCMP_FMIN, 32'h0000_0000, 32'h8000_0000, 2'b01, 5'd3, 32'h8000_0000, 1'b0);
    run_op("t2.fmax_zeros",  FCMP_FMAX, 32'h0000_0000, 32'h8000_0000, 2'b01, 5'd4, 32'h0000_0000, 1'b0);
    run_op("t3.fle_qnan",    FCMP_FLE,  32'h7FC0_0000, 32'h3F80_0000, 2'b01, 5'd5, 32'd0, 1'b1);
    run_op("t3.feq_qnan",    FCMP_FEQ,  32'h7FC0_0000, 32'h3F80_0000, 2'b01, 5'd6, 32'd0, 1'b0);
    run_op("t3.fmax_qnan",   FCMP_FMAX, 32'h7FC0_0000, 32'h3F80_0000, 2'b01, 5'd7, 32'h3F80_0000, 1'b0);
    run_op("t4.fmin_snan",   FCMP_FMIN, 32'h7F80_0001, 32'h7FC0_0000, 2'b10, 5'd8, 32'h7FC0_0000, 1'b1);
    run_op("x.flt_bothneg",  FCMP_FLT,  32'hC000_0000, 32'hBF80_0000, 2'b01, 5'd9, 32'd1, 1'b0);
    run_op("x.fle_equal",    FCMP_FLE,  32'h4040_0000, 32'h4040_0000, 2'b00, 5'd10, 32'd1, 1'b0);
    run_op("x.feq_mag11",    FCMP_FEQ,  32'h3F80_0000, 32'h3F80_0000, 2'b11, 5'd11, 32'd1, 1'b0);
    run_op("x.feq_inf",      FCMP_FEQ,  32'h7F80_0000, 32'h7F80_0000, 2'b00, 5'd12, 32'd1, 1'b0);
    run_op("x.flt_denorm",   FCMP_FLT,  32'h0000_0001, 32'h0000_0002, 2'b10, 5'd13, 32'd1, 1'b0);
    run_op("x.flt_negzero",  FCMP_FLT,  32'h8000_0000, 32'h0000_0000, 2'b00, 5'd14, 32'd0, 1'b0);
    run_op("x.fmax_snan",    FCMP_FMAX, 32'h7F80_0001, 32'h3F80_0000, 2'b01, 5'd15, 32'h3F80_0000, 1'b1);
    run_op("x.fmin_pos",     FCMP_FMIN, 32'h4000_0000, 32'h3F80_0000, 2'b01, 5'd16, 32'h3F80_0000, 1'b0);
    run_op("x.bad_op",       3'b101,    32'h4000_0000, 32'h3F80_0000, 2'b01, 5'd17, 32'd0, 1'b0);

    // Back-to-back stream with output stall on cycles 3-5
    s_op[0] = FCMP_FMAX; s_a[0] = 32'h4000_0000; s_b[0] = 32'h3F80_0000; s_mag[0] = 2'b01; s_exp[0] = 32'h4000_0000;
    s_op[1] = FCMP_FMIN; s_a[1] = 32'h4000_0000; s_b[1] = 32'h3F80_0000; s_mag[1] = 2'b01; s_exp[1] = 32'h3F80_0000;
    s_op[2] = FCMP_FLT;  s_a[2] = 32'h3F80_0000; s_b[2] = 32'h4000_0000; s_mag[2] = 2'b10; s_exp[2] = 32'd1;
    s_op[3] = FCMP_FEQ;  s_a[3] = 32'h4040_0000; s_b[3] = 32'h4040_0000; s_mag[3] = 2'b00; s_exp[3] = 32'd1;
    ix = 0; rx = 0; held = 1'b0; prev_res = 32'h0; prev_tag = 5'h0;
    for (int c = 0; c < 20 && rx < 4; c++) begin
      @(negedge CLK);
      bus.out_ready = !(c >= 3 && c <= 5);
      if (ix < 4) drive(s_op[ix], s_a[ix], s_b[ix], s_mag[ix], 5'(ix + 20));
      else bus.in_valid = 1'b0;
      #1;
      if (held) begin
        chk("t5.hold_vld", {31'b0, bus.out_valid}, 32'd1);
        chk("t5.hold_res", bus.result, prev_res);
        chk("t5.hold_tag", {27'b0, bus.out_tag}, {27'b0, prev_tag});
      end
      if (c == 3) chk("t5.in_ready_full", {31'b0, bus.in_ready}, 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        chk("t5.res_order", bus.result, s_exp[rx]);
        chk("t5.tag_order", {27'b0, bus.out_tag}, 32'(rx + 20));
        rx++;
      end
      held     = bus.out_valid && !bus.out_ready;
      prev_res = bus.result;
      prev_tag = bus.out_tag;
      if (bus.in_valid && bus.in_ready) ix++;
    end
    bus.in_valid = 1'b0;
    chk("t5.delivered", 32'(rx), 32'd4);

    // Flush blocks acceptance in its own cycle
    @(negedge CLK);
    flush = 1'b1;
    drive(FCMP_FEQ, 32'h0, 32'h0, 2'b00, 5'd3);
    #1 chk("t6.flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge CLK);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk("t6.flush_no_accept", {31'b0, bus.out_valid}, 32'd0);

    // Two ops in flight, output stalled, then flush
    bus.out_ready = 1'b0;
    @(negedge CLK);
    drive(FCMP_FMAX, 32'h4000_0000, 32'h3F80_0000, 2'b01, 5'd7);
    @(negedge CLK);
    drive(FCMP_FMIN, 32'h4000_0000, 32'h3F80_0000, 2'b01, 5'd8);
    @(negedge CLK);
    drive(FCMP_FEQ, 32'h0, 32'h0, 2'b00, 5'd9);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("t6.flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t6.flush_in_ready_after", {31'b0, bus.in_ready}, 32'd1);
    @(negedge CLK);
    #1 chk("t6.flush_s1_dropped", {31'b0, bus.out_valid}, 32'd0);

    // Reset while a result is held under stall
    bus.out_ready = 1'b0;
    @(negedge CLK);
    drive(FCMP_FMAX, 32'h7F80_0001, 32'h4000_0000, 2'b01, 5'h1F);
    @(negedge CLK);
    drive(FCMP_FLT, 32'h3F80_0000, 32'h4000_0000, 2'b10, 5'h1E);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    #1;
    chk("t6.pre_rst_vld", {31'b0, bus.out_valid}, 32'd1);
    chk("t6.pre_rst_res", bus.result, 32'h4000_0000);
    chk("t6.pre_rst_nv",  {31'b0, bus.nv}, 32'd1);
    RESET_N = 1'b0;
    @(negedge CLK);
    #1;
    chk("t6.rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t6.rst_result",    bus.result, 32'h0);
    chk("t6.rst_nv",        {31'b0, bus.nv}, 32'd0);
    chk("t6.rst_out_tag",   {27'b0, bus.out_tag}, 32'd0);
    RESET_N = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    #1 chk("t6.rst_s1_dropped", {31'b0, bus.out_valid}, 32'd0);

    run_op("t6.recover", FCMP_FLE, 32'hBF80_0000, 32'hC000_0000, 2'b10, 5'd6, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
